// File: rtl/apb_pkg.sv
// Shared types and width helpers for the multi-completer APB requester bridge.
// Latency: none (declarations only).
// Backpressure: not applicable.
package apb_pkg;

   // Bridge sequencing states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DERR   = 2'd3
   } apb_state_e;

   // Width of the completer-index field; a single completer still needs one bit
   function automatic int idx_width(input int num_slv);
      return (num_slv <= 1) ? 1 : $clog2(num_slv);
   endfunction

   // Wait-counter width: at least 5 bits, wider if the limit needs it
   function automatic int cnt_width(input int limit);
      return ($clog2(limit + 1) > 5) ? $clog2(limit + 1) : 5;
   endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Completer decode: index field of the request address -> completer index and in-range hit.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, consumed by the bridge only when it accepts.
module apb_addr_decode #(
   parameter int NUM_SLV = 4,
   parameter int IDX_W   = 2
) (
   input  logic [IDX_W-1:0] sel_field,
   output logic [IDX_W-1:0] idx,
   output logic             hit
);

   assign idx = sel_field;

   // When the index field cannot express an absent completer every index is a hit
   generate
      if (NUM_SLV >= (1 << IDX_W)) begin : g_full
         assign hit = 1'b1;
      end else begin : g_part
         assign hit = (sel_field < IDX_W'(NUM_SLV));
      end
   endgenerate

endmodule

// File: rtl/apb_bridge_nslave.sv
// APB requester bridge: one request port fanned out to NUM_SLV completers on a shared bus.
// Latency: accept -> done is 3 cycles plus completer wait states; 2 cycles for a decode miss.
// Backpressure: req_ready low while a transfer is in flight; optional APB_TIMEOUT_EN bounds ACCESS.
module apb_bridge_nslave
   import apb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_SLV = 4,
   parameter int SEL_LSB = 12,
   parameter int TIMEOUT = 16
) (
   input  logic                      pclk,
   input  logic                      presetn,
   input  logic                      ptransfer,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic [DATA_W-1:0]         req_wdata,
   output logic                      done,
   output logic [DATA_W-1:0]         rdata,
   output logic                      err,
   output logic [NUM_SLV-1:0]        psel,
   output logic                      penable,
   output logic                      pwrite,
   output logic [ADDR_W-1:0]         paddr,
   output logic [DATA_W-1:0]         pwdata,
   input  logic [NUM_SLV*DATA_W-1:0] prdata,
   input  logic [NUM_SLV-1:0]        pready,
   input  logic [NUM_SLV-1:0]        pslverr
);

   localparam int IDX_W = idx_width(NUM_SLV);

   apb_state_e        state;
   apb_state_e        state_nxt;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  dec_idx;
   logic              dec_hit;

   logic              sel_rdy;
   logic              sel_err;
   logic [DATA_W-1:0] sel_rdata;

   logic              fin;
   logic              fin_err;
   logic [DATA_W-1:0] fin_rdata;

   apb_addr_decode #(
      .NUM_SLV (NUM_SLV),
      .IDX_W   (IDX_W)
   ) u_decode (
      .sel_field (req_addr[SEL_LSB +: IDX_W]),
      .idx       (dec_idx),
      .hit       (dec_hit)
   );

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = cnt_width(TIMEOUT);
   logic [CNT_W-1:0] wcnt;
   logic             limit_hit;

   assign limit_hit = (wcnt == CNT_W'(TIMEOUT - 1));

   // Count ACCESS cycles spent waiting on the selected completer; restart on every SETUP
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         wcnt <= '0;
      end else if (state == SETUP) begin
         wcnt <= '0;
      end else if (state == ACCESS && !sel_rdy) begin
         wcnt <= wcnt + 1'b1;
      end
   end
`endif

   // Pick the selected completer's ready/error/read-data; other completers are ignored
   always_comb begin
      sel_rdy   = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_rdy   = pready[i];
            sel_err   = pslverr[i];
            sel_rdata = prdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Drive the one-hot select for the whole SETUP/ACCESS window only
   always_comb begin
      psel = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if ((state == SETUP || state == ACCESS) && idx_q == IDX_W'(i)) begin
            psel[i] = 1'b1;
         end
      end
   end

   assign penable   = (state == ACCESS);
   assign req_ready = (state == IDLE);

   // Next-state and completion decode; a ready completer beats the wait limit
   always_comb begin
      state_nxt = state;
      fin       = 1'b0;
      fin_err   = 1'b0;
      fin_rdata = '0;
      case (state)
         IDLE: begin
            if (ptransfer) begin
               state_nxt = dec_hit ? SETUP : DERR;
            end
         end
         SETUP: begin
            state_nxt = ACCESS;
         end
         ACCESS: begin
            if (sel_rdy) begin
               state_nxt = IDLE;
               fin       = 1'b1;
               fin_err   = sel_err;
               fin_rdata = pwrite ? '0 : sel_rdata;
            end
`ifdef APB_TIMEOUT_EN
            else if (limit_hit) begin
               state_nxt = IDLE;
               fin       = 1'b1;
               fin_err   = 1'b1;
            end
`endif
         end
         DERR: begin
            state_nxt = IDLE;
            fin       = 1'b1;
            fin_err   = 1'b1;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, captured request and the registered one-cycle completion
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state  <= IDLE;
         idx_q  <= '0;
         paddr  <= '0;
         pwdata <= '0;
         pwrite <= 1'b0;
         done   <= 1'b0;
         rdata  <= '0;
         err    <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= fin;
         err   <= fin_err;
         rdata <= fin_rdata;
         if (state == IDLE && ptransfer) begin
            idx_q  <= dec_idx;
            paddr  <= req_addr;
            pwdata <= req_wdata;
            pwrite <= req_write;
         end
      end
   end

endmodule

// File: tb/tb_apb_bridge_nslave.sv
// Directed plus randomized bench for the APB bridge against a cycle-schedule reference model.
// Latency: not applicable.
// Backpressure: completers insert configurable wait states; request noise is driven while busy.
module tb_apb_bridge_nslave;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int NS   = 3;
   localparam int SLSB = 12;
   localparam int TO   = 16;

   logic          pclk = 1'b0;
   logic          presetn;
   logic          ptransfer;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          done;
   logic [DW-1:0] rdata;
   logic          err;
   logic [NS-1:0] psel;
   logic          penable;
   logic          pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [NS*DW-1:0] prdata;
   logic [NS-1:0] pready;
   logic [NS-1:0] pslverr;

   int checks = 0;
   int errors = 0;

   // Completer environment configuration
   int            wcfg = 0;
   logic          errcfg = 1'b0;
   logic [NS-1:0] noise_rdy = '0;
   logic [NS-1:0] noise_err = '0;
   int            acnt [NS];

   always #5 pclk = ~pclk;

   apb_bridge_nslave #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .NUM_SLV (NS),
      .SEL_LSB (SLSB),
      .TIMEOUT (TO)
   ) dut (
      .pclk      (pclk),
      .presetn   (presetn),
      .ptransfer (ptransfer),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .done      (done),
      .rdata     (rdata),
      .err       (err),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   // Each completer counts the ACCESS cycles it has already seen
   always @(posedge pclk) begin
      for (int i = 0; i < NS; i++) begin
         acnt[i] <= (psel[i] && penable) ? acnt[i] + 1 : 0;
      end
   end

   // Selected completer answers after wcfg wait states; unselected ones drive noise
   always_comb begin
      pready  = '0;
      pslverr = '0;
      for (int i = 0; i < NS; i++) begin
         pready[i]  = psel[i] ? (penable && acnt[i] >= wcfg) : noise_rdy[i];
         pslverr[i] = psel[i] ? errcfg : noise_err[i];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_psel"},    64'(psel),      64'd0);
      chk({tag, "_penable"}, 64'(penable),   64'd0);
      chk({tag, "_pwrite"},  64'(pwrite),    64'd0);
      chk({tag, "_paddr"},   64'(paddr),     64'd0);
      chk({tag, "_pwdata"},  64'(pwdata),    64'd0);
      chk({tag, "_done"},    64'(done),      64'd0);
      chk({tag, "_rdata"},   64'(rdata),     64'd0);
      chk({tag, "_err"},     64'(err),       64'd0);
      chk({tag, "_rdy"},     64'(req_ready), 64'd1);
   endtask

   // One transfer: request issued in the current (idle) cycle, then every following
   // cycle is compared against the schedule the protocol rules predict.
   task automatic xfer(input string name, input bit wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input int w, input bit serr,
                       input bit use_rv, input logic [DW-1:0] rv);
      int            idx;
      bit            hit;
      bit            tmo;
      int            n_acc;
      int            total;
      logic [NS-1:0] exp_sel;
      logic          exp_err;
      logic [DW-1:0] exp_rd;
      logic [NS-1:0] e_sel;
      logic          e_pen;
      logic          e_done;
      logic          e_rdy;

      wcfg   = w;
      errcfg = serr;
      prdata = {$urandom, $urandom, $urandom};
      idx    = int'((addr >> SLSB) & 32'h3);
      hit    = (idx < NS);
      if (hit && use_rv) prdata[idx*DW +: DW] = rv;

      // Reference schedule
      tmo = 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo = hit && (w >= TO);
`endif
      n_acc   = tmo ? TO : w + 1;
      total   = hit ? n_acc + 2 : 2;
      exp_sel = hit ? NS'(1 << idx) : '0;
      exp_err = !hit || tmo || serr;
      exp_rd  = (hit && !tmo && !wr) ? prdata[idx*DW +: DW] : '0;

      chk({name, "_accept_rdy"}, 64'(req_ready), 64'd1);
      ptransfer = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;

      for (int k = 1; k <= total; k++) begin
         @(posedge pclk);
         #1;
         e_done = (k == total);
         e_rdy  = e_done;
         e_pen  = hit && (k >= 2) && (k <= n_acc + 1);
         e_sel  = (hit && k <= n_acc + 1) ? exp_sel : '0;
         chk($sformatf("%s_c%0d_psel", name, k),    64'(psel),      64'(e_sel));
         chk($sformatf("%s_c%0d_penable", name, k), 64'(penable),   64'(e_pen));
         chk($sformatf("%s_c%0d_done", name, k),    64'(done),      64'(e_done));
         chk($sformatf("%s_c%0d_rdy", name, k),     64'(req_ready), 64'(e_rdy));
         if (hit && !e_done) begin
            chk($sformatf("%s_c%0d_paddr", name, k),  64'(paddr),  64'(addr));
            chk($sformatf("%s_c%0d_pwrite", name, k), 64'(pwrite), 64'(wr));
            chk($sformatf("%s_c%0d_pwdata", name, k), 64'(pwdata), 64'(wd));
         end
         if (e_done) begin
            chk({name, "_err"},   64'(err),   64'(exp_err));
            chk({name, "_rdata"}, 64'(rdata), 64'(exp_rd));
            ptransfer = 1'b0;
         end else begin
            // Requests while busy must be ignored
            ptransfer = 1'($urandom_range(0, 1));
            req_write = 1'($urandom_range(0, 1));
            req_addr  = $urandom;
            req_wdata = $urandom;
         end
         noise_rdy = NS'($urandom);
         noise_err = NS'($urandom);
      end
   endtask

   initial begin
      presetn   = 1'b0;
      ptransfer = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      prdata    = '0;
      for (int i = 0; i < NS; i++) acnt[i] = 0;

      repeat (3) @(posedge pclk);
      #1;
      chk_reset_outputs("reset");
      presetn = 1'b1;

      // Directed cases
      xfer("wr_s1_nowait", 1'b1, 32'h0000_1004, 32'hA5A5_0001, 0, 1'b0, 1'b0, '0);
      xfer("rd_s2_3wait",  1'b0, 32'h0000_2000, 32'h0,         3, 1'b0, 1'b1, 32'hDEAD_BEEF);
      xfer("rd_miss",      1'b0, 32'h0000_3000, 32'h0,         0, 1'b0, 1'b0, '0);
      xfer("wr_miss",      1'b1, 32'h0000_3ABC, 32'h1234_5678, 0, 1'b0, 1'b0, '0);
      xfer("rd_s0_slverr", 1'b0, 32'h0000_0010, 32'h0,         1, 1'b1, 1'b0, '0);
      xfer("wr_s0_slverr", 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 0, 1'b1, 1'b0, '0);

      // Randomized traffic, back-to-back or with idle gaps
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 2) == 0) begin
            @(posedge pclk);
            #1;
            chk($sformatf("gap%0d_rdy", t),  64'(req_ready), 64'd1);
            chk($sformatf("gap%0d_done", t), 64'(done),      64'd0);
         end
         xfer($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), $urandom, $urandom,
              $urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'b0, '0);
      end

      // Wait-limit boundaries; without the limit these simply complete late
      xfer("wait_lim_m1", 1'b0, 32'h0000_1000, 32'h0,         TO - 1, 1'b0, 1'b0, '0);
      xfer("wait_lim",    1'b0, 32'h0000_2000, 32'h0,         TO,     1'b0, 1'b0, '0);
      xfer("wait_long",   1'b1, 32'h0000_0040, 32'h0BAD_0BAD, 110,    1'b0, 1'b0, '0);

      // Reset while in ACCESS aborts with no completion
      wcfg      = 50;
      errcfg    = 1'b0;
      ptransfer = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h0000_1008;
      req_wdata = 32'h7777_0000;
      @(posedge pclk);
      #1;
      ptransfer = 1'b0;
      @(posedge pclk);
      #1;
      chk("abort_in_access", 64'(penable), 64'd1);
      presetn = 1'b0;
      @(posedge pclk);
      #1;
      chk_reset_outputs("abort");
      presetn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge pclk);
         #1;
         chk($sformatf("abort_nodone%0d", k), 64'(done), 64'd0);
      end
      xfer("after_abort", 1'b0, 32'h0000_1008, 32'h0, 2, 1'b0, 1'b1, 32'h0102_0304);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
